// File: rtl/m_pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor. The carry chain is split across STAGES
// register stages with a valid/ready handshake and full backpressure.
module m_pipe_csel_adder #(
   parameter int WIDTH  = 64,
   parameter int BLK    = 8,
   parameter int STAGES = 2
) (
   input  logic             i_clk_1,
   input  logic             i_rst_1,
   input  logic             i_valid_1,
   output logic             o_ready_1,
   input  logic [WIDTH-1:0] i_adderOperand1,
   input  logic [WIDTH-1:0] i_adderOperand2,
   input  logic             i_cIn_1,
   input  logic             i_sub_1,
   output logic             o_valid_1,
   input  logic             i_ready_1,
   output logic [WIDTH-1:0] o_adderSum,
   output logic             o_cOut_1,
   output logic             o_ovf_1,
   output logic             o_zero_1
);

   localparam int SW   = WIDTH / STAGES;
   localparam int NBLK = SW / BLK;
   localparam int LAST = STAGES - 1;

   if (STAGES < 1 || BLK < 1 || (WIDTH % (BLK * STAGES)) != 0) begin : g_bad_cfg
      $error("m_pipe_csel_adder: WIDTH must be a multiple of BLK*STAGES");
   end

   // One stage's slice: every block forms both carry-in sums, the incoming carry picks one.
   function automatic logic [SW:0] csel_slice(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b,
                                              input logic          cin);
      logic [SW-1:0] s;
      logic          c;
      logic [BLK:0]  r0;
      logic [BLK:0]  r1;
      // NOTE: blocking assignments here, the carry must ripple block to block within one evaluation.
      c = cin;
      s = '0;
      for (int j = 0; j < NBLK; j++) begin
         r0 = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]};
         r1 = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
         {c, s[j*BLK +: BLK]} = c ? r1 : r0;
      end
      return {c, s};
   endfunction

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic              c_q   [STAGES];
   logic              ovf_q;
   logic              zero_q;

   logic [STAGES-1:0] src_v;
   logic [WIDTH-1:0]  src_a [STAGES];
   logic [WIDTH-1:0]  src_b [STAGES];
   logic [WIDTH-1:0]  src_s [STAGES];
   logic              src_c [STAGES];
   logic [WIDTH-1:0]  nxt_s [STAGES];
   logic              nxt_c [STAGES];
   logic              ovf_nxt;
   logic              zero_nxt;

   // A stage moves when it is empty or its successor moves; the last one follows i_ready_1.
   always_comb begin : ready_chain
      logic go;
      go = i_ready_1;
      for (int k = STAGES - 1; k >= 0; k--) begin
         go     = !v_q[k] || go;
         adv[k] = go;
      end
   end

   assign o_ready_1 = adv[0] && !i_rst_1;

   always_comb begin : datapath
      logic [SW:0] res;
      // NOTE: every comb output gets a value on every pass so no latch is inferred.
      src_v[0] = i_valid_1;
      src_a[0] = i_adderOperand1;
      src_b[0] = i_sub_1 ? ~i_adderOperand2 : i_adderOperand2;
      src_s[0] = '0;
      src_c[0] = i_sub_1 | i_cIn_1;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = v_q[k-1];
         src_a[k] = a_q[k-1];
         src_b[k] = b_q[k-1];
         src_s[k] = sum_q[k-1];
         src_c[k] = c_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         res                    = csel_slice(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
         nxt_s[k]               = src_s[k];
         nxt_s[k][k*SW +: SW]   = res[SW-1:0];
         nxt_c[k]               = res[SW];
      end
      ovf_nxt  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                 (nxt_s[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
      zero_nxt = (nxt_s[LAST] == '0);
   end

   always_ff @(posedge i_clk_1) begin
      if (i_rst_1) begin
         // NOTE: data registers are reset too, so the outputs read zero right after reset.
         v_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            c_q[k]   <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               v_q[k] <= src_v[k];
               if (src_v[k]) begin
                  a_q[k]   <= src_a[k];
                  b_q[k]   <= src_b[k];
                  sum_q[k] <= nxt_s[k];
                  c_q[k]   <= nxt_c[k];
               end
            end
         end
         if (adv[LAST] && src_v[LAST]) begin
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
         end
      end
   end

   assign o_valid_1  = v_q[LAST];
   assign o_adderSum = sum_q[LAST];
   assign o_cOut_1   = c_q[LAST];
   assign o_ovf_1    = ovf_q;
   assign o_zero_1   = zero_q;

endmodule

// File: tb/tb_m_pipe_csel_adder.sv
// Bench for m_pipe_csel_adder: three configurations (64/8/2, 32/4/4, 64/8/1) checked
// against an arithmetic reference model and a capacity-based handshake model.
module tb_m_pipe_csel_adder;

   localparam int ND = 3;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [ND];
   logic        in_valid  [ND];
   logic        in_ready  [ND];
   logic [63:0] op_a      [ND];
   logic [63:0] op_b      [ND];
   logic        cin       [ND];
   logic        sub       [ND];
   logic        out_valid [ND];
   logic        out_ready [ND];
   logic        cout_o    [ND];
   logic        ovf_o     [ND];
   logic        zero_o    [ND];
   logic [63:0] sum_o     [ND];
   logic [63:0] sum_0, sum_2;
   logic [31:0] sum_1;

   int checks   = 0;
   int failures = 0;

   logic [63:0] stim_a [$];
   logic [63:0] stim_b [$];
   logic        stim_c [$];
   logic        stim_s [$];

   m_pipe_csel_adder #(.WIDTH(64), .BLK(8), .STAGES(2)) u_d0 (
      .i_clk_1(clk), .i_rst_1(rst[0]), .i_valid_1(in_valid[0]), .o_ready_1(in_ready[0]),
      .i_adderOperand1(op_a[0]), .i_adderOperand2(op_b[0]), .i_cIn_1(cin[0]), .i_sub_1(sub[0]),
      .o_valid_1(out_valid[0]), .i_ready_1(out_ready[0]), .o_adderSum(sum_0),
      .o_cOut_1(cout_o[0]), .o_ovf_1(ovf_o[0]), .o_zero_1(zero_o[0]));

   m_pipe_csel_adder #(.WIDTH(32), .BLK(4), .STAGES(4)) u_d1 (
      .i_clk_1(clk), .i_rst_1(rst[1]), .i_valid_1(in_valid[1]), .o_ready_1(in_ready[1]),
      .i_adderOperand1(op_a[1][31:0]), .i_adderOperand2(op_b[1][31:0]), .i_cIn_1(cin[1]),
      .i_sub_1(sub[1]), .o_valid_1(out_valid[1]), .i_ready_1(out_ready[1]), .o_adderSum(sum_1),
      .o_cOut_1(cout_o[1]), .o_ovf_1(ovf_o[1]), .o_zero_1(zero_o[1]));

   m_pipe_csel_adder #(.WIDTH(64), .BLK(8), .STAGES(1)) u_d2 (
      .i_clk_1(clk), .i_rst_1(rst[2]), .i_valid_1(in_valid[2]), .o_ready_1(in_ready[2]),
      .i_adderOperand1(op_a[2]), .i_adderOperand2(op_b[2]), .i_cIn_1(cin[2]), .i_sub_1(sub[2]),
      .o_valid_1(out_valid[2]), .i_ready_1(out_ready[2]), .o_adderSum(sum_2),
      .o_cOut_1(cout_o[2]), .o_ovf_1(ovf_o[2]), .o_zero_1(zero_o[2]));

   always_comb begin
      sum_o[0] = sum_0;
      sum_o[1] = {32'h0, sum_1};
      sum_o[2] = sum_2;
   end

   function automatic int width_of(input int d);
      return (d == 1) ? 32 : 64;
   endfunction

   function automatic int stages_of(input int d);
      case (d)
         0:       return 2;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic logic [63:0] mask_of(input int w);
      return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic signed [66:0] sext(input logic [63:0] v, input int w);
      logic [66:0] r;
      r = {3'b000, v};
      if (v[w-1]) r = r - (67'd1 << w);
      return signed'(r);
   endfunction

   // Reference: unsigned sum modulo 2^w, carry as "exceeds range / no borrow",
   // overflow as "true signed result not representable in w bits".
   function automatic res_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic c, input logic s);
      logic [63:0]            m, a, b;
      logic [65:0]            ut;
      logic signed [66:0]     st, lim;
      res_t                   r;
      m   = mask_of(w);
      a   = a_in & m;
      b   = b_in & m;
      lim = 67'sd1 <<< (w - 1);
      if (s) begin
         ut     = {2'b00, a} - {2'b00, b};
         r.cout = (a >= b);
         st     = sext(a, w) - sext(b, w);
      end else begin
         ut     = {2'b00, a} + {2'b00, b} + {65'd0, c};
         r.cout = ut[w];
         st     = sext(a, w) + sext(b, w) + (c ? 67'sd1 : 67'sd0);
      end
      r.sum  = ut[63:0] & m;
      r.zero = (r.sum == 64'd0);
      r.ovf  = (st >= lim) || (st < -lim);
      return r;
   endfunction

   task automatic push(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
      stim_a.push_back(a);
      stim_b.push_back(b);
      stim_c.push_back(c);
      stim_s.push_back(s);
   endtask

   task automatic push_random(input int n);
      for (int i = 0; i < n; i++)
         push({$urandom(), $urandom()}, {$urandom(), $urandom()},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // mode 0: full rate, exact latency checked; 1: ready 1,0,0 repeating; 2: random valid/ready
   task automatic stream(input int d, input int mode);
      res_t        exp_q [$];
      int          acc_cyc [$];
      res_t        e;
      int          cyc = 0;
      int          lat;
      bit          stalled = 0;
      logic [63:0] h_sum;
      logic        h_c, h_o, h_z;
      logic        exp_rdy;
      int          w  = width_of(d);
      int          st = stages_of(d);
      while ((stim_a.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid[d] !== 1'b1 || sum_o[d] !== h_sum || cout_o[d] !== h_c ||
                ovf_o[d] !== h_o || zero_o[d] !== h_z) begin
               failures++;
               $display("FAIL hold d=%0d cyc=%0d got v=%b sum=%h c=%b o=%b z=%b, need v=1 sum=%h c=%b o=%b z=%b",
                        d, cyc, out_valid[d], sum_o[d], cout_o[d], ovf_o[d], zero_o[d], h_sum, h_c, h_o, h_z);
            end
         end
         out_ready[d] = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         in_valid[d]  = (stim_a.size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
         if (stim_a.size() > 0) begin
            op_a[d] = stim_a[0];
            op_b[d] = stim_b[0];
            cin[d]  = stim_c[0];
            sub[d]  = stim_s[0];
         end
         #1;
         exp_rdy = (exp_q.size() < st) || out_ready[d];
         checks++;
         if (in_ready[d] !== exp_rdy) begin
            failures++;
            $display("FAIL ready d=%0d cyc=%0d got %b need %b (held=%0d)", d, cyc, in_ready[d], exp_rdy, exp_q.size());
         end
         if (out_valid[d] === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious d=%0d cyc=%0d got valid result sum=%h need none", d, cyc, sum_o[d]);
            end else if (out_ready[d]) begin
               e   = exp_q.pop_front();
               lat = cyc - acc_cyc.pop_front();
               checks++;
               if (sum_o[d] !== e.sum || cout_o[d] !== e.cout || ovf_o[d] !== e.ovf || zero_o[d] !== e.zero) begin
                  failures++;
                  $display("FAIL result d=%0d cyc=%0d got sum=%h c=%b o=%b z=%b need sum=%h c=%b o=%b z=%b",
                           d, cyc, sum_o[d], cout_o[d], ovf_o[d], zero_o[d], e.sum, e.cout, e.ovf, e.zero);
               end
               if (mode == 0) begin
                  checks++;
                  if (lat != st) begin
                     failures++;
                     $display("FAIL latency d=%0d got %0d need %0d", d, lat, st);
                  end
               end
            end
         end
         stalled = (out_valid[d] === 1'b1) && !out_ready[d];
         h_sum   = sum_o[d];
         h_c     = cout_o[d];
         h_o     = ovf_o[d];
         h_z     = zero_o[d];
         if (in_valid[d] && in_ready[d] === 1'b1) begin
            exp_q.push_back(model(w, stim_a[0], stim_b[0], stim_c[0], stim_s[0]));
            acc_cyc.push_back(cyc);
            stim_a.delete(0);
            stim_b.delete(0);
            stim_c.delete(0);
            stim_s.delete(0);
         end else if (in_ready[d] !== 1'b1) begin
            op_a[d] = {$urandom(), $urandom()};
            op_b[d] = {$urandom(), $urandom()};
         end
         cyc++;
      end
      if (cyc >= 2000) begin
         checks++;
         failures++;
         $display("FAIL timeout d=%0d got %0d results outstanding need 0", d, exp_q.size());
         stim_a.delete();
         stim_b.delete();
         stim_c.delete();
         stim_s.delete();
      end
      @(negedge clk);
      in_valid[d] = 1'b0;
   endtask

   task automatic test_reset(input int d);
      rst[d]       = 1'b1;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (in_ready[d] !== 1'b0) begin
         failures++;
         $display("FAIL ready_in_reset d=%0d got %b need 0", d, in_ready[d]);
      end
      rst[d] = 1'b0;
      #1;
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || sum_o[d] !== 64'd0 ||
          cout_o[d] !== 1'b0 || ovf_o[d] !== 1'b0 || zero_o[d] !== 1'b0) begin
         failures++;
         $display("FAIL reset_state d=%0d got rdy=%b v=%b sum=%h c=%b o=%b z=%b need rdy=1 v=0 sum=0 c=0 o=0 z=0",
                  d, in_ready[d], out_valid[d], sum_o[d], cout_o[d], ovf_o[d], zero_o[d]);
      end
   endtask

   task automatic test_add(input int d);
      push(mask_of(width_of(d)), 64'd1, 1'b0, 1'b0);
      push(64'd1234, 64'd4321, 1'b1, 1'b0);
      stream(d, 0);
   endtask

   task automatic test_sub(input int d);
      int w = width_of(d);
      push(64'd0, 64'd1, 1'b1, 1'b1);
      push(64'd1 << (w - 1), 64'd1, 1'b0, 1'b1);
      push(64'd5, 64'd5, 1'b0, 1'b1);
      stream(d, 0);
   endtask

   task automatic test_add_ovf(input int d);
      int w = width_of(d);
      push(mask_of(w - 1), 64'd1, 1'b1, 1'b0);
      push(64'd1 << (w - 1), 64'd1 << (w - 1), 1'b0, 1'b0);
      stream(d, 0);
   endtask

   task automatic test_boundary(input int d);
      int sw = width_of(d) / stages_of(d);
      for (int k = 0; k < stages_of(d) - 1; k++)
         push(mask_of((k + 1) * sw), 64'd1, 1'b0, 1'b0);
      push(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      push(mask_of(sw), 64'd1, 1'b0, 1'b1);
      push(64'd0, mask_of(width_of(d)), 1'b1, 1'b0);
      stream(d, 0);
   endtask

   task automatic test_backpressure(input int d);
      push_random(10);
      stream(d, 1);
   endtask

   task automatic test_random(input int d);
      push_random(40);
      stream(d, 2);
   endtask

   task automatic test_reset_mid(input int d);
      bit stale = 0;
      out_ready[d] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid[d] = 1'b1;
         op_a[d]     = {$urandom(), $urandom()};
         op_b[d]     = {$urandom(), $urandom()};
         cin[d]      = 1'b0;
         sub[d]      = 1'b0;
      end
      @(negedge clk);
      in_valid[d] = 1'b0;
      rst[d]      = 1'b1;
      #1;
      checks++;
      if (in_ready[d] !== 1'b0) begin
         failures++;
         $display("FAIL ready_during_reset d=%0d got %b need 0", d, in_ready[d]);
      end
      @(negedge clk);
      rst[d]       = 1'b0;
      out_ready[d] = 1'b1;
      checks++;
      if (out_valid[d] !== 1'b0) begin
         failures++;
         $display("FAIL valid_after_reset d=%0d got %b need 0", d, out_valid[d]);
      end
      repeat (8) begin
         @(negedge clk);
         if (out_valid[d] !== 1'b0) stale = 1;
      end
      checks++;
      if (stale) begin
         failures++;
         $display("FAIL stale_result d=%0d got valid after reset need none", d);
      end
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst[d]       = 1'b1;
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
         op_a[d]      = 64'd0;
         op_b[d]      = 64'd0;
         cin[d]       = 1'b0;
         sub[d]       = 1'b0;
      end
      for (int d = 0; d < ND; d++) begin
         test_reset(d);
         test_add(d);
         test_sub(d);
         test_add_ovf(d);
         test_boundary(d);
         test_backpressure(d);
         test_random(d);
         test_reset_mid(d);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
